// File: rtl/egpn_edge_sel_if.sv
// Signal bundle for egpn_edge_sel: channel inputs, per-channel controls and
// the registered level/pulse outputs with their event counts.
interface egpn_edge_sel_if #(
  parameter int CH     = 4,
  parameter int FILT_W = 4,
  parameter int CNT_W  = 8
);
  logic [CH-1:0]       Sin;
  logic [CH-1:0]       Pol;
  logic [2*CH-1:0]     Mode;
  logic [FILT_W-1:0]   Filt_Len;
  logic                Cnt_Clr;
  logic [CH-1:0]       Sout;
  logic [CH*CNT_W-1:0] Evt_Cnt;

  modport master (
    output Sin, Pol, Mode, Filt_Len, Cnt_Clr,
    input  Sout, Evt_Cnt
  );

  modport slave (
    input  Sin, Pol, Mode, Filt_Len, Cnt_Clr,
    output Sout, Evt_Cnt
  );
endinterface

// File: rtl/egpn_edge_sel.sv
// Multi-channel edge/polarity selector: synchronise, invert, glitch-filter,
// then emit a level or edge pulse per channel with a saturating event count.
module egpn_edge_sel #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CNT_W       = 8
) (
  input logic           Clock,
  input logic           Reset,
  egpn_edge_sel_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_BOTH  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [FILT_W-1:0] FILT_ONE = FILT_W'(1);

  logic [CH-1:0]       sync_q [SYNC_STAGES];
  logic [CH-1:0]       p_q;
  logic [CH-1:0]       f;
  logic [CH-1:0]       f_d;
  logic [FILT_W-1:0]   fcnt [CH];
  logic [CH-1:0]       sout_q;
  logic [CNT_W-1:0]    evt_cnt [CH];

  logic [CH-1:0]       rise;
  logic [CH-1:0]       fall;
  logic [CH-1:0]       sout_d;
  logic [CH-1:0]       evt;
  logic [CH*CNT_W-1:0] evt_flat;

  // Synchroniser chain and polarity register. Pol is folded in after the
  // synchroniser, so toggling it looks exactly like an input transition.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      // NOTE: the synchroniser array is cleared on reset because a stale
      // stage would otherwise produce a spurious event after release.
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      p_q <= '0;
    end else begin
      sync_q[0] <= bus.Sin;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      p_q <= sync_q[SYNC_STAGES-1] ^ bus.Pol;
    end
  end

  // Glitch filter: f follows p_q only after Filt_Len+1 consecutive
  // disagreeing cycles; Filt_Len is compared live.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      f <= '0;
      for (int i = 0; i < CH; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (p_q[i] == f[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] >= bus.Filt_Len) begin
          f[i]    <= p_q[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FILT_ONE;
        end
      end
    end
  end

  // Output selection and counted event per channel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    sout_d = '0;
    evt    = '0;
    rise   = f & ~f_d;
    fall   = ~f & f_d;
    for (int i = 0; i < CH; i++) begin
      case (mode_e'(bus.Mode[2*i +: 2]))
        MODE_LEVEL: begin sout_d[i] = f[i];              evt[i] = rise[i];           end
        MODE_RISE:  begin sout_d[i] = rise[i];           evt[i] = rise[i];           end
        MODE_FALL:  begin sout_d[i] = fall[i];           evt[i] = fall[i];           end
        MODE_BOTH:  begin sout_d[i] = rise[i] | fall[i]; evt[i] = rise[i] | fall[i]; end
        default:    begin sout_d[i] = 1'b0;              evt[i] = 1'b0;              end
      endcase
    end
  end

  // Edge-delay, output register and saturating counters share one edge so
  // Evt_Cnt moves together with the Sout pulse it counts.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      f_d    <= '0;
      sout_q <= '0;
      for (int i = 0; i < CH; i++) evt_cnt[i] <= '0;
    end else begin
      f_d    <= f;
      sout_q <= sout_d;
      for (int i = 0; i < CH; i++) begin
        if (bus.Cnt_Clr)
          evt_cnt[i] <= '0;
        else if (evt[i] && evt_cnt[i] != CNT_MAX)
          evt_cnt[i] <= evt_cnt[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    evt_flat = '0;
    for (int i = 0; i < CH; i++) evt_flat[CNT_W*i +: CNT_W] = evt_cnt[i];
  end

  assign bus.Sout    = sout_q;
  assign bus.Evt_Cnt = evt_flat;

endmodule

// File: tb/tb_egpn_edge_sel.sv
// Scoreboard bench for egpn_edge_sel: expectations are queued with the cycle
// they are due on and compared on the falling edge of that cycle.
module tb_egpn_edge_sel;

  localparam int CH     = 4;
  localparam int SYNC   = 2;
  localparam int FILT_W = 4;
  localparam int CNT_W  = 3;
  localparam int LAT    = SYNC + 3;

  logic Clock = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  egpn_edge_sel_if #(.CH(CH), .FILT_W(FILT_W), .CNT_W(CNT_W)) bus ();

  egpn_edge_sel #(.CH(CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W), .CNT_W(CNT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    string tag;
    int    at;
    int    ch;    // -1: all outputs must be zero
    logic  sout;
    int    cnt;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, want);
    end
  endtask

  task automatic exp_ch(input string tag, input int at, input int ch, input logic sout, input int cnt);
    exp_t e;
    e.tag = tag; e.at = at; e.ch = ch; e.sout = sout; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic exp_zero(input string tag, input int at);
    exp_ch(tag, at, -1, 1'b0, 0);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge Clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        if (sb[i].ch < 0) begin
          check({sb[i].tag, "_sout"}, 32'(bus.Sout), 32'(0));
          check({sb[i].tag, "_cnt"},  32'(bus.Evt_Cnt), 32'(0));
        end else begin
          check({sb[i].tag, "_sout"}, 32'(bus.Sout[sb[i].ch]), 32'(sb[i].sout));
          check({sb[i].tag, "_cnt"},  32'(bus.Evt_Cnt[CNT_W*sb[i].ch +: CNT_W]), 32'(sb[i].cnt));
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, e, g, f, h, i0, j0, j, r2;

    Reset        = 1'b0;
    bus.Sin      = '0;
    bus.Pol      = 4'b0100;
    bus.Mode     = {2'b10, 2'b11, 2'b01, 2'b00};  // ch3 fall, ch2 both, ch1 rise, ch0 level
    bus.Filt_Len = '0;
    bus.Cnt_Clr  = 1'b0;

    exp_zero("reset1", 1);
    exp_zero("reset2", 2);
    wait_to(2);

    // Release: ch2 idles inverted, so a filtered rising event appears.
    Reset = 1'b1;
    t = cyc;
    exp_ch("postrst_pre",  t + 2, 2, 1'b0, 0);
    exp_ch("postrst_rise", t + 3, 2, 1'b1, 1);
    exp_ch("postrst_post", t + 4, 2, 1'b0, 1);
    exp_ch("postrst_ch3",  t + 3, 3, 1'b0, 0);

    // Level pass-through, Filt_Len=0.
    wait_to(20);
    t = cyc;
    bus.Sin[0] = 1'b1;
    exp_ch("lvl_before", t + LAT - 1, 0, 1'b0, 0);
    exp_ch("lvl_rise",   t + LAT,     0, 1'b1, 1);
    exp_ch("lvl_hold",   t + LAT + 1, 0, 1'b1, 1);
    wait_to(t + 10);
    t = cyc;
    bus.Sin[0] = 1'b0;
    exp_ch("lvl_fall_pre", t + LAT - 1, 0, 1'b1, 1);
    exp_ch("lvl_fall",     t + LAT,     0, 1'b0, 1);
    exp_ch("lvl_fall_cnt", t + LAT + 1, 0, 1'b0, 1);
    wait_to(t + 10);
    bus.Filt_Len = 4'd3;

    // Glitch rejection on ch1 (rise mode): 3-cycle pulse rejected, 4 passes.
    wait_to(cyc + 2);
    d = cyc;
    bus.Sin[1] = 1'b1;
    for (int k = 1; k <= 14; k++) exp_ch("glitch3", d + k, 1, 1'b0, 0);
    wait_to(d + 3);
    bus.Sin[1] = 1'b0;
    wait_to(d + 20);
    e = cyc;
    bus.Sin[1] = 1'b1;
    exp_ch("pulse4_pre",  e + LAT + 2, 1, 1'b0, 0);
    exp_ch("pulse4_edge", e + LAT + 3, 1, 1'b1, 1);
    for (int k = LAT + 4; k <= LAT + 11; k++) exp_ch("pulse4_after", e + k, 1, 1'b0, 1);
    wait_to(e + 4);
    bus.Sin[1] = 1'b0;
    wait_to(e + 25);

    // Clear all counters, then polarity-inverted both-edge toggles on ch2.
    g = cyc;
    bus.Cnt_Clr = 1'b1;
    exp_ch("clr_ch0", g + 1, 0, 1'b0, 0);
    exp_ch("clr_ch1", g + 1, 1, 1'b0, 0);
    exp_ch("clr_ch2", g + 1, 2, 1'b0, 0);
    tick();
    bus.Cnt_Clr = 1'b0;
    wait_to(g + 5);
    f = cyc;
    bus.Sin[2] = 1'b1;
    exp_ch("both1_pre",  f + LAT + 2,  2, 1'b0, 0);
    exp_ch("both1",      f + LAT + 3,  2, 1'b1, 1);
    exp_ch("both1_post", f + LAT + 4,  2, 1'b0, 1);
    exp_ch("both2_pre",  f + LAT + 12, 2, 1'b0, 1);
    exp_ch("both2",      f + LAT + 13, 2, 1'b1, 2);
    exp_ch("both2_post", f + LAT + 14, 2, 1'b0, 2);
    wait_to(f + 10);
    bus.Sin[2] = 1'b0;
    wait_to(f + 30);

    // Falling mode on ch3 with saturation at 7; events 8 cycles apart.
    h = cyc;
    exp_ch("fall_idle", h + LAT + 6, 3, 1'b0, 0);
    for (int k = 0; k < 10; k++) begin
      int c;
      c = (k + 1 > 7) ? 7 : k + 1;
      exp_ch("sat_edge",  h + 12 + 8*k, 3, 1'b1, c);
      exp_ch("sat_after", h + 13 + 8*k, 3, 1'b0, c);
    end
    for (int k = 0; k < 10; k++) begin
      wait_to(h + 8*k);
      bus.Sin[3] = 1'b1;
      wait_to(h + 8*k + 4);
      bus.Sin[3] = 1'b0;
    end
    wait_to(h + 95);

    // Clear wins over a simultaneous rising event on ch0.
    i0 = cyc;
    bus.Sin[0] = 1'b1;
    exp_ch("clrpri_pre_ch0", i0 + 7, 0, 1'b0, 0);
    exp_ch("clrpri_pre_ch3", i0 + 7, 3, 1'b0, 7);
    exp_ch("clrpri_ch0",     i0 + 8, 0, 1'b1, 0);
    exp_ch("clrpri_ch3",     i0 + 8, 3, 1'b0, 0);
    exp_ch("clrpri_hold",    i0 + 9, 0, 1'b1, 0);
    wait_to(i0 + 7);
    bus.Cnt_Clr = 1'b1;
    tick();
    bus.Cnt_Clr = 1'b0;
    wait_to(i0 + 15);

    // Reset during a filter count on ch0, with a nonzero ch1 count pending.
    j0 = cyc;
    bus.Sin[0] = 1'b0;
    bus.Sin[1] = 1'b1;
    exp_ch("pre_rst_ch1", j0 + 8, 1, 1'b1, 1);
    exp_ch("pre_rst_ch0", j0 + 8, 0, 1'b0, 0);
    wait_to(j0 + 14);
    j = cyc;
    bus.Sin[0] = 1'b1;
    exp_ch("in_count_ch1", j + 5, 1, 1'b0, 1);
    wait_to(j + 5);
    Reset = 1'b0;
    exp_zero("midrst1", j + 6);
    exp_zero("midrst2", j + 7);
    wait_to(j + 7);
    Reset = 1'b1;
    r2 = cyc;
    exp_ch("refill_pre",  r2 + LAT + 2, 0, 1'b0, 0);
    exp_ch("refill_rise", r2 + LAT + 3, 0, 1'b1, 1);
    exp_ch("refill_ch1",  r2 + LAT + 3, 1, 1'b1, 1);
    exp_ch("refill_ch2",  r2 + 6,       2, 1'b1, 1);
    exp_ch("refill_ch3",  r2 + LAT + 3, 3, 1'b0, 0);
    wait_to(r2 + 15);

    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
